// File: rtl/cic_pkg.sv
// Shared CIC constants and width helpers, used by the decimator and the interpolator.
package cic_pkg;

    localparam int unsigned CIC_N = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit growth of an N-stage, M=1 CIC is N*log2(R) over the input width.
    function automatic int unsigned cic_acc_width(input int unsigned in_width,
                                                  input int unsigned rate);
        return in_width + CIC_N * clog2(rate);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section, differential delay 1: y = x - x_delayed, advanced only when en is high.
module cic_comb_stage #(
    parameter int unsigned ACC_WIDTH = 21
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [ACC_WIDTH-1:0] x,
    output logic signed [ACC_WIDTH-1:0] y
);

    logic signed [ACC_WIDTH-1:0] x_dly_q;
    logic signed [ACC_WIDTH-1:0] y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_dly_q <= '0;
            y_q     <= '0;
        end else if (en) begin
            x_dly_q <= x;
            y_q     <= x - x_dly_q;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/cic_dec_n3.sv
// 3-stage CIC decimator: integrators at input rate, decimate by DECIMATION_RATE, combs at output rate.
// Define CIC_DEC_ROUND_EN for round-half-up with positive saturation instead of floor truncation.
module cic_dec_n3
    import cic_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH     = 12,
    parameter int unsigned ACC_WIDTH       = 21,
    parameter int unsigned OUTPUT_WIDTH    = 16,
    parameter int unsigned DECIMATION_RATE = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           nd,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    output logic                           rdy
);

    localparam int unsigned CNT_W = clog2(DECIMATION_RATE);
    localparam int unsigned DROP  = ACC_WIDTH - OUTPUT_WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION_RATE - 1);

    logic signed [ACC_WIDTH-1:0]    din_ext;
    logic signed [ACC_WIDTH-1:0]    i1_q, i2_q, i3_q;
    logic signed [ACC_WIDTH-1:0]    c1_q, c2, c3, c_out;
    logic [CNT_W-1:0]               cnt_q;
    logic                           dec_v_q;
    logic                           out_v_q;
    logic                           rdy_q;
    logic signed [OUTPUT_WIDTH-1:0] dout_q;
    logic signed [OUTPUT_WIDTH-1:0] scaled;

    assign din_ext = {{(ACC_WIDTH - INPUT_WIDTH){din[INPUT_WIDTH-1]}}, din};

    // Integrators wrap modulo 2^ACC_WIDTH; the combs undo the wrap exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            cnt_q   <= '0;
            dec_v_q <= 1'b0;
            c1_q    <= '0;
            out_v_q <= 1'b0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            if (nd) begin
                i1_q  <= i1_q + din_ext;
                i2_q  <= i2_q + i1_q;
                i3_q  <= i3_q + i2_q;
                cnt_q <= cnt_q + CNT_ONE;
            end
            dec_v_q <= nd && (cnt_q == CNT_LAST);
            if (dec_v_q) begin
                c1_q <= i3_q;
            end
            out_v_q <= dec_v_q;
            rdy_q   <= out_v_q;
            if (out_v_q) begin
                dout_q <= scaled;
            end
        end
    end

    cic_comb_stage #(.ACC_WIDTH(ACC_WIDTH)) u_comb1 (
        .clk (clk),
        .rst (rst),
        .en  (dec_v_q),
        .x   (c1_q),
        .y   (c2)
    );

    cic_comb_stage #(.ACC_WIDTH(ACC_WIDTH)) u_comb2 (
        .clk (clk),
        .rst (rst),
        .en  (dec_v_q),
        .x   (c2),
        .y   (c3)
    );

    cic_comb_stage #(.ACC_WIDTH(ACC_WIDTH)) u_comb3 (
        .clk (clk),
        .rst (rst),
        .en  (dec_v_q),
        .x   (c3),
        .y   (c_out)
    );

`ifdef CIC_DEC_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] HALF_LSB = (ACC_WIDTH + 1)'(1) << (DROP - 1);

    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [OUTPUT_WIDTH:0] rnd_top;

    // One guard bit keeps the rounding add from wrapping; only the positive side can overflow.
    always_comb begin
        rnd_sum = {c_out[ACC_WIDTH-1], c_out} + HALF_LSB;
        rnd_top = (OUTPUT_WIDTH + 1)'(rnd_sum >>> DROP);
        scaled  = rnd_top[OUTPUT_WIDTH-1:0];
        if (!rnd_top[OUTPUT_WIDTH] && rnd_top[OUTPUT_WIDTH-1]) begin
            scaled = {1'b0, {(OUTPUT_WIDTH - 1){1'b1}}};
        end
    end
`else
    always_comb begin
        scaled = OUTPUT_WIDTH'(c_out >>> DROP);
    end
`endif

    assign dout = dout_q;
    assign rdy  = rdy_q;

endmodule
